// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals between two requesters, an ALU, a consumer and the arbiter
//   req0/req1 : valid/ready handshake with 4-bit opcode and two WIDTH-bit operands each
//   alu       : opcode/operands out to the ALU, combinational result back in
//   rsp       : valid/ready response carrying requester id, result data and illegal-opcode flag
interface alu_arbiter_if #(parameter int WIDTH = 32);
    logic             i_req0_valid;
    logic             o_req0_ready;
    logic [3:0]       i_req0_op;
    logic [WIDTH-1:0] i_req0_a;
    logic [WIDTH-1:0] i_req0_b;
    logic             i_req1_valid;
    logic             o_req1_ready;
    logic [3:0]       i_req1_op;
    logic [WIDTH-1:0] i_req1_a;
    logic [WIDTH-1:0] i_req1_b;
    logic [3:0]       o_alu_op;
    logic [WIDTH-1:0] o_alu_a;
    logic [WIDTH-1:0] o_alu_b;
    logic [WIDTH-1:0] i_alu_data;
    logic             o_rsp_valid;
    logic             o_rsp_id;
    logic [WIDTH-1:0] o_rsp_data;
    logic             o_rsp_err;
    logic             i_rsp_ready;
    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        input  i_alu_data, i_rsp_ready,
        output o_req0_ready, o_req1_ready, o_alu_op, o_alu_a, o_alu_b,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
    );
    modport master (
        output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        output i_alu_data, i_rsp_ready,
        input  o_req0_ready, o_req1_ready, o_alu_op, o_alu_a, o_alu_b,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters, one op per 3 cycles
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : alu_arbiter_if slave modport (requesters, ALU, response)
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         i_clk,
    input logic         i_rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             any_valid, grant, accept, illegal;
    always_comb begin
        any_valid = bus.i_req0_valid | bus.i_req1_valid;
        // contention goes to the pointer; otherwise whichever side is valid
        grant = (bus.i_req0_valid & bus.i_req1_valid) ? prio_q : bus.i_req1_valid;
        accept = (state_q == IDLE) & any_valid;
        illegal = op_q > 4'b1010;
        state_d = state_q;
        prio_d = prio_q;
        id_d = id_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d = rsp_err_q;
        if (accept) begin
            state_d = EXEC;
            prio_d = ~grant;
            id_d = grant;
            op_d = grant ? bus.i_req1_op : bus.i_req0_op;
            a_d = grant ? bus.i_req1_a : bus.i_req0_a;
            b_d = grant ? bus.i_req1_b : bus.i_req0_b;
        end else if (state_q == EXEC) begin
            state_d = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d = id_q;
            rsp_err_d = illegal;
            rsp_data_d = illegal ? '0 : bus.i_alu_data;
        end else if (state_q == RESP && bus.i_rsp_ready) begin
            state_d = IDLE;
            rsp_valid_d = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            prio_q <= 1'b0;
            id_q <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q <= prio_d;
            id_q <= id_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign bus.o_req0_ready = accept & ~grant;
    assign bus.o_req1_ready = accept & grant;
    assign bus.o_alu_op = op_q;
    assign bus.o_alu_a = a_q;
    assign bus.o_alu_b = b_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id = rsp_id_q;
    assign bus.o_rsp_data = rsp_data_q;
    assign bus.o_rsp_err = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    alu_arbiter_if #(.WIDTH(32)) bus ();
    alu_arbiter #(.WIDTH(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // reference ALU: 0 add, 1 sub, 6 and, 10 pass B, anything else xor
    always_comb begin
        case (bus.o_alu_op)
            4'd0:    bus.i_alu_data = bus.o_alu_a + bus.o_alu_b;
            4'd1:    bus.i_alu_data = bus.o_alu_a - bus.o_alu_b;
            4'd6:    bus.i_alu_data = bus.o_alu_a & bus.o_alu_b;
            4'd10:   bus.i_alu_data = bus.o_alu_b;
            default: bus.i_alu_data = bus.o_alu_a ^ bus.o_alu_b;
        endcase
    end
    typedef struct {
        logic        v0;
        logic [3:0]  op0;
        logic [31:0] a0, b0;
        logic        v1;
        logic [3:0]  op1;
        logic [31:0] a1, b1;
        logic        id;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.i_req0_valid = 0; bus.i_req0_op = 0; bus.i_req0_a = 0; bus.i_req0_b = 0;
        bus.i_req1_valid = 0; bus.i_req1_op = 0; bus.i_req1_a = 0; bus.i_req1_b = 0;
        bus.i_rsp_ready = 0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask
    task automatic run_vec(input vec_t v, input int k);
        @(negedge clk);
        bus.i_req0_valid = v.v0; bus.i_req0_op = v.op0; bus.i_req0_a = v.a0; bus.i_req0_b = v.b0;
        bus.i_req1_valid = v.v1; bus.i_req1_op = v.op1; bus.i_req1_a = v.a1; bus.i_req1_b = v.b1;
        #1;
        chk($sformatf("v%0d ready0", k), bus.o_req0_ready, !v.id);
        chk($sformatf("v%0d ready1", k), bus.o_req1_ready, v.id);
        @(negedge clk);
        idle_inputs();
        bus.i_req0_a = 32'h1234; bus.i_req1_b = 32'h5678;
        #1;
        chk($sformatf("v%0d alu_op", k), bus.o_alu_op, v.id ? v.op1 : v.op0);
        chk($sformatf("v%0d alu_a", k), bus.o_alu_a, v.id ? v.a1 : v.a0);
        chk($sformatf("v%0d alu_b", k), bus.o_alu_b, v.id ? v.b1 : v.b0);
        chk($sformatf("v%0d early_valid", k), bus.o_rsp_valid, 0);
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", k), bus.o_rsp_valid, 1);
        chk($sformatf("v%0d rsp_id", k), bus.o_rsp_id, v.id);
        chk($sformatf("v%0d rsp_data", k), bus.o_rsp_data, v.data);
        chk($sformatf("v%0d rsp_err", k), bus.o_rsp_err, v.err);
        bus.i_rsp_ready = 1;
        @(negedge clk);
        chk($sformatf("v%0d rsp_drop", k), bus.o_rsp_valid, 0);
        bus.i_rsp_ready = 0;
    endtask
    initial begin
        vecs[0] = '{1, 4'h0, 32'd5, 32'd7, 0, 4'h0, 0, 0, 0, 32'd12, 0};
        vecs[1] = '{0, 4'h0, 0, 0, 1, 4'h1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 0};
        vecs[2] = '{1, 4'hC, 32'd9, 32'd4, 0, 4'h0, 0, 0, 0, 32'd0, 1};
        vecs[3] = '{1, 4'h6, 32'hF0, 32'h3C, 0, 4'h0, 0, 0, 0, 32'h30, 0};
        vecs[4] = '{1, 4'h0, 32'd1, 32'd2, 1, 4'hA, 32'd0, 32'd9, 1, 32'd9, 0};
        vecs[5] = '{1, 4'h0, 32'd1, 32'd2, 1, 4'hA, 32'd0, 32'd9, 0, 32'd3, 0};
        vecs[6] = '{0, 4'h0, 0, 0, 1, 4'hF, 32'd6, 32'd6, 1, 32'd0, 1};
        vecs[7] = '{1, 4'hA, 32'd0, 32'hDEAD, 0, 4'h0, 0, 0, 0, 32'hDEAD, 0};
        idle_inputs();
        #1;
        chk("reset rsp_valid", bus.o_rsp_valid, 0);
        chk("reset rsp_data", bus.o_rsp_data, 0);
        chk("reset alu_op", bus.o_alu_op, 0);
        chk("reset alu_a", bus.o_alu_a, 0);
        do_reset();
        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);
        // continuous contention with the consumer always ready
        do_reset();
        @(negedge clk);
        bus.i_req0_valid = 1; bus.i_req0_op = 0; bus.i_req0_a = 10; bus.i_req0_b = 1;
        bus.i_req1_valid = 1; bus.i_req1_op = 1; bus.i_req1_a = 10; bus.i_req1_b = 1;
        bus.i_rsp_ready = 1;
        begin
            int n = 0;
            int last = 0;
            logic exp_id = 0;
            for (int c = 0; c < 12; c++) begin
                #1;
                chk("rr ready_excl", bus.o_req0_ready & bus.o_req1_ready, 0);
                if (bus.o_rsp_valid) begin
                    chk("rr id", bus.o_rsp_id, exp_id);
                    chk("rr data", bus.o_rsp_data, exp_id ? 32'd9 : 32'd11);
                    if (n > 0) chk("rr spacing", c - last, 3);
                    last = c;
                    exp_id = ~exp_id;
                    n++;
                end
                @(negedge clk);
            end
            chk("rr count", n, 4);
        end
        idle_inputs();
        // response held under back-pressure while requester 0 waits
        do_reset();
        @(negedge clk);
        bus.i_req1_valid = 1; bus.i_req1_op = 1; bus.i_req1_a = 3; bus.i_req1_b = 5;
        @(negedge clk);
        idle_inputs();
        bus.i_req0_valid = 1; bus.i_req0_op = 0; bus.i_req0_a = 1; bus.i_req0_b = 1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold valid", bus.o_rsp_valid, 1);
            chk("hold id", bus.o_rsp_id, 1);
            chk("hold data", bus.o_rsp_data, 32'hFFFF_FFFE);
            chk("hold no_ready", bus.o_req0_ready | bus.o_req1_ready, 0);
            @(negedge clk);
        end
        bus.i_rsp_ready = 1;
        #1;
        chk("hold resp_no_ready", bus.o_req0_ready, 0);
        @(negedge clk);
        chk("hold release", bus.o_rsp_valid, 0);
        idle_inputs();
        // asynchronous reset in the middle of EXEC
        @(negedge clk);
        bus.i_req0_valid = 1; bus.i_req0_op = 0; bus.i_req0_a = 5; bus.i_req0_b = 7;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid exec alu_a", bus.o_alu_a, 5);
        #1;
        rst = 1;
        #1;
        chk("async alu_a", bus.o_alu_a, 0);
        chk("async alu_b", bus.o_alu_b, 0);
        chk("async rsp_valid", bus.o_rsp_valid, 0);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post rst no_rsp", bus.o_rsp_valid, 0);
        end
        bus.i_req0_valid = 1; bus.i_req0_a = 32'hA0;
        bus.i_req1_valid = 1; bus.i_req1_a = 32'hA1;
        #1;
        chk("post rst ready0", bus.o_req0_ready, 1);
        chk("post rst ready1", bus.o_req1_ready, 0);
        @(negedge clk);
        chk("post rst grant_a", bus.o_alu_a, 32'hA0);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the ALU port widths match it.
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_req0_valid  input  1  requester 0 has an operation pending.
REQ-005 o_req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 i_req0_op  input  4  requester 0 ALU opcode (ALU op encoding 0000..1010).
REQ-007 i_req0_a / i_req0_b  input  WIDTH each  requester 0 operands.
REQ-008 i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b  same widths and meanings for requester 1.
REQ-009 o_alu_op  output  4  opcode driven to the shared ALU.
REQ-010 o_alu_a / o_alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-011 i_alu_data  input  WIDTH  combinational ALU result.
REQ-012 o_rsp_valid  output  1  response available.
REQ-013 o_rsp_id  output  1  requester index owning the response.
REQ-014 o_rsp_data  output  WIDTH  captured ALU result.
REQ-015 o_rsp_err  output  1  opcode was illegal (> 4'b1010).
REQ-016 i_rsp_ready  input  1  consumer takes the response this cycle.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-018 IDLE: no valid -> stay IDLE, both readies 0.
REQ-019 IDLE, one valid -> grant that requester; its ready = 1 combinationally that cycle; the other ready = 0.
REQ-020 IDLE, both valid -> grant requester named by round-robin pointer prio; only the granted ready = 1.
REQ-021 On grant: latch op, a, b and grant id into internal registers; next state EXEC; prio <= ~granted id.
REQ-022 o_req0_ready and o_req1_ready SHALL be 0 in EXEC and RESP and never both 1.
REQ-023 o_alu_op/o_alu_a/o_alu_b SHALL be driven directly from the latched registers in every state (stable through EXEC).
REQ-024 EXEC: capture i_alu_data into o_rsp_data; o_rsp_err <= (op > 4'b1010); if illegal, o_rsp_data <= 0; next state RESP.
REQ-025 RESP: o_rsp_valid = 1; o_rsp_id/data/err held stable until i_rsp_ready = 1.
REQ-026 RESP with i_rsp_ready = 1 -> IDLE next cycle; o_rsp_valid 0 from that cycle; no new request accepted in the RESP cycle.
REQ-027 Latency: accept at cycle N -> o_rsp_valid at N+2 minimum; max throughput one operation per 3 cycles.
REQ-028 Requester valid deasserting outside IDLE SHALL have no effect on an in-flight operation.
REQ-029 Opcode 4'b1010 (pass operand B) is legal; only 4'b1011..4'b1111 set o_rsp_err.
REQ-030 Fairness: under continuous valid on both, grants alternate 0,1,0,1,...

Reset
REQ-031 i_rst SHALL immediately (without clock) force state IDLE, prio 0, latched op/a/b/id 0, o_rsp_valid 0, o_rsp_id 0, o_rsp_data 0, o_rsp_err 0.
REQ-032 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced after release.
REQ-033 First cycle after reset release with both valid SHALL grant requester 0.

Verification
REQ-034 Req0 only, op 0000, a=5, b=7 -> ready0 at N, o_alu_a=5/b=7 at N+1, rsp_valid at N+2 with id 0, data 12, err 0.
REQ-035 Both valid continuously, rsp_ready tied 1 -> grant order 0,1,0,1; responses at 3-cycle spacing with matching ids.
REQ-036 Req1 op 0001, a=3, b=5; hold rsp_ready 0 for 4 cycles -> data 32'hFFFF_FFFE, id 1 stable all cycles, no new ready asserted.
REQ-037 Req0 op 4'b1100 -> rsp_err 1, rsp_data 0; next op 0110 a=F0 b=3C -> err 0, data 32'h30.
REQ-038 Assert i_rst mid-EXEC -> rsp_valid stays 0, outputs 0 immediately; after release both valid -> requester 0 granted.
